// File: rtl/axi_lite_wr_decoder_1x4_if.sv
// AXI4-Lite write-channel bundle; N_PORTS lanes of per-port valid/ready/resp,
// with address and data shared across lanes.
interface axi_lite_wr_decoder_1x4_if #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned N_PORTS = 1
);
   logic [N_PORTS-1:0]   awvalid;
   logic [N_PORTS-1:0]   awready;
   logic [ADDR_W-1:0]    awaddr;
   logic [N_PORTS-1:0]   wvalid;
   logic [N_PORTS-1:0]   wready;
   logic [DATA_W-1:0]    wdata;
   logic [DATA_W/8-1:0]  wstrb;
   logic [N_PORTS-1:0]   bvalid;
   logic [N_PORTS-1:0]   bready;
   logic [2*N_PORTS-1:0] bresp;

   modport master (
      output awvalid, awaddr, wvalid, wdata, wstrb, bready,
      input  awready, wready, bvalid, bresp
   );

   modport slave (
      input  awvalid, awaddr, wvalid, wdata, wstrb, bready,
      output awready, wready, bvalid, bresp
   );
endinterface

// File: rtl/axi_lite_wr_decoder_1x4.sv
// AXI4-Lite write-path decoder: one master, four slaves selected by the top two
// address bits; one outstanding write, DECERR for slaves absent from SLV_EN.
module axi_lite_wr_decoder_1x4 #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   parameter logic [3:0]  SLV_EN = 4'b1111
) (
   input logic                    clk,
   input logic                    rst,
   axi_lite_wr_decoder_1x4_if.slave  mst,
   axi_lite_wr_decoder_1x4_if.master slv
);

   typedef enum logic [2:0] {StIdle, StFwd, StResp, StErr, StEbresp} state_e;

   state_e            state_q, state_d;
   logic [1:0]        sel_q, sel_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              aw_done_q, aw_done_d;
   logic              w_done_q, w_done_d;

   logic [3:0] sel_oh;
   logic       aw_ok, w_ok, aw_fin, w_fin, bv;

   assign sel_oh = 4'b0001 << sel_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         sel_q     <= '0;
         addr_q    <= '0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         addr_q    <= addr_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      addr_d      = addr_q;
      aw_done_d   = aw_done_q;
      w_done_d    = w_done_q;
      aw_ok       = 1'b0;
      w_ok        = 1'b0;
      aw_fin      = 1'b0;
      w_fin       = 1'b0;
      bv          = 1'b0;
      mst.awready = 1'b0;
      mst.wready  = 1'b0;
      mst.bvalid  = 1'b0;
      mst.bresp   = 2'b00;
      slv.awvalid = 4'b0000;
      slv.wvalid  = 4'b0000;
      slv.bready  = 4'b0000;
      slv.awaddr  = addr_q;
      slv.wdata   = mst.wdata;
      slv.wstrb   = mst.wstrb;

      unique case (state_q)
         StIdle: begin
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            if (mst.awvalid) begin
               sel_d   = mst.awaddr[ADDR_W-1 -: 2];
               addr_d  = mst.awaddr;
               state_d = SLV_EN[mst.awaddr[ADDR_W-1 -: 2]] ? StFwd : StErr;
            end
         end
         StFwd: begin
            slv.awvalid = sel_oh & {4{mst.awvalid & ~aw_done_q}};
            slv.wvalid  = sel_oh & {4{mst.wvalid & ~w_done_q}};
            aw_ok       = slv.awready[sel_q] & ~aw_done_q;
            w_ok        = slv.wready[sel_q] & ~w_done_q;
            mst.awready = aw_ok;
            mst.wready  = w_ok;
            aw_fin      = aw_done_q | (mst.awvalid & aw_ok);
            w_fin       = w_done_q | (mst.wvalid & w_ok);
            aw_done_d   = aw_fin;
            w_done_d    = w_fin;
            if (aw_fin && w_fin) state_d = StResp;
         end
         StResp: begin
            bv          = slv.bvalid[sel_q];
            mst.bvalid  = bv;
            mst.bresp   = bv ? slv.bresp[{sel_q, 1'b0} +: 2] : 2'b00;
            slv.bready  = sel_oh & {4{mst.bready}};
            if (bv && mst.bready) state_d = StIdle;
         end
         StErr: begin
            // Accept and drop both channels so the master is never stalled.
            aw_ok       = ~aw_done_q;
            w_ok        = ~w_done_q;
            mst.awready = aw_ok;
            mst.wready  = w_ok;
            aw_fin      = aw_done_q | (mst.awvalid & aw_ok);
            w_fin       = w_done_q | (mst.wvalid & w_ok);
            aw_done_d   = aw_fin;
            w_done_d    = w_fin;
            if (aw_fin && w_fin) state_d = StEbresp;
         end
         StEbresp: begin
            mst.bvalid = 1'b1;
            mst.bresp  = 2'b11;
            if (mst.bready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

endmodule

// File: tb/tb_axi_lite_wr_decoder_1x4.sv
// Bench for axi_lite_wr_decoder_1x4: directed and random writes checked cycle by
// cycle against a timeline model; a second instance has slave 3 disabled.
module tb_axi_lite_wr_decoder_1x4;

   logic clk;
   logic rst;
   logic use_e;

   logic        m_awvalid, m_wvalid, m_bready;
   logic [31:0] m_awaddr, m_wdata;
   logic [3:0]  m_wstrb;
   logic [3:0]  s_awready, s_wready, s_bvalid;
   logic [7:0]  s_bresp;

   logic        ob_m_awready, ob_m_wready, ob_m_bvalid;
   logic [1:0]  ob_m_bresp;
   logic [3:0]  ob_s_awvalid, ob_s_wvalid, ob_s_bready, ob_s_wstrb;
   logic [31:0] ob_s_awaddr, ob_s_wdata;

   int n_checks;
   int n_fail;

   axi_lite_wr_decoder_1x4_if #(.ADDR_W(32), .DATA_W(32), .N_PORTS(1)) ma ();
   axi_lite_wr_decoder_1x4_if #(.ADDR_W(32), .DATA_W(32), .N_PORTS(4)) sa ();
   axi_lite_wr_decoder_1x4_if #(.ADDR_W(32), .DATA_W(32), .N_PORTS(1)) me ();
   axi_lite_wr_decoder_1x4_if #(.ADDR_W(32), .DATA_W(32), .N_PORTS(4)) se ();

   axi_lite_wr_decoder_1x4 #(.ADDR_W(32), .DATA_W(32), .SLV_EN(4'b1111)) dut (
      .clk(clk), .rst(rst), .mst(ma), .slv(sa)
   );

   axi_lite_wr_decoder_1x4 #(.ADDR_W(32), .DATA_W(32), .SLV_EN(4'b0111)) dut_e (
      .clk(clk), .rst(rst), .mst(me), .slv(se)
   );

   // Only the instance selected by use_e sees live handshakes.
   assign ma.awvalid = m_awvalid & ~use_e;
   assign me.awvalid = m_awvalid & use_e;
   assign ma.wvalid  = m_wvalid & ~use_e;
   assign me.wvalid  = m_wvalid & use_e;
   assign ma.bready  = m_bready & ~use_e;
   assign me.bready  = m_bready & use_e;
   assign ma.awaddr  = m_awaddr;
   assign me.awaddr  = m_awaddr;
   assign ma.wdata   = m_wdata;
   assign me.wdata   = m_wdata;
   assign ma.wstrb   = m_wstrb;
   assign me.wstrb   = m_wstrb;
   assign sa.awready = use_e ? 4'b0 : s_awready;
   assign se.awready = use_e ? s_awready : 4'b0;
   assign sa.wready  = use_e ? 4'b0 : s_wready;
   assign se.wready  = use_e ? s_wready : 4'b0;
   assign sa.bvalid  = use_e ? 4'b0 : s_bvalid;
   assign se.bvalid  = use_e ? s_bvalid : 4'b0;
   assign sa.bresp   = s_bresp;
   assign se.bresp   = s_bresp;

   assign ob_m_awready = use_e ? me.awready : ma.awready;
   assign ob_m_wready  = use_e ? me.wready  : ma.wready;
   assign ob_m_bvalid  = use_e ? me.bvalid  : ma.bvalid;
   assign ob_m_bresp   = use_e ? me.bresp   : ma.bresp;
   assign ob_s_awvalid = use_e ? se.awvalid : sa.awvalid;
   assign ob_s_wvalid  = use_e ? se.wvalid  : sa.wvalid;
   assign ob_s_bready  = use_e ? se.bready  : sa.bready;
   assign ob_s_awaddr  = use_e ? se.awaddr  : sa.awaddr;
   assign ob_s_wdata   = use_e ? se.wdata   : sa.wdata;
   assign ob_s_wstrb   = use_e ? se.wstrb   : sa.wstrb;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int imax(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   task automatic chk(input string tag, input int t, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s (t=%0d): observed %0h expected %0h", tag, t, obs, exp);
      end
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, " m_awready"}, -1, ob_m_awready, 0);
      chk({tag, " m_wready"}, -1, ob_m_wready, 0);
      chk({tag, " m_bvalid"}, -1, ob_m_bvalid, 0);
      chk({tag, " m_bresp"}, -1, ob_m_bresp, 0);
      chk({tag, " s_awvalid"}, -1, ob_s_awvalid, 0);
      chk({tag, " s_wvalid"}, -1, ob_s_wvalid, 0);
      chk({tag, " s_bready"}, -1, ob_s_bready, 0);
   endtask

   // One write starting at a negedge with the selected DUT idle. Slave timing is
   // given in absolute cycles from the AW sample (cycle 0); abort_at >= 0 asserts
   // reset after that cycle instead of completing the response.
   task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_at, input int w_at,
                           input int b_dly, input int bready_at,
                           input logic [1:0] bresp, input int abort_at);
      logic [3:0]  en_e;
      logic [3:0]  oh;
      logic [31:0] rnd;
      logic        en;
      int          idx, awc, wc, r, bstart, bc;
      bit          aw_pend, w_pend, done;
      logic        exp_bv;

      en_e   = 4'b0111;
      idx    = int'(addr[31:30]);
      oh     = 4'b0001 << idx;
      en     = use_e ? en_e[idx] : 1'b1;
      awc    = en ? imax(1, aw_at) : 1;
      wc     = en ? imax(1, w_at) : 1;
      r      = imax(awc, wc) + 1;
      bstart = en ? r + b_dly : r;
      bc     = imax(bstart, bready_at);

      aw_pend  = 1'b1;
      w_pend   = 1'b1;
      done     = 1'b0;
      m_awaddr = addr;
      m_wdata  = data;
      m_wstrb  = strb;
      s_bresp  = 8'($urandom);
      s_bresp[2*idx +: 2] = bresp;

      for (int t = 0; t < 60 && !done; t++) begin
         rnd       = $urandom;
         m_awvalid = aw_pend;
         m_wvalid  = w_pend;
         m_bready  = (t >= bready_at);
         s_awready = (rnd[3:0] & ~oh) | ((t >= aw_at) ? oh : 4'b0);
         s_wready  = (rnd[7:4] & ~oh) | ((t >= w_at) ? oh : 4'b0);
         s_bvalid  = (rnd[11:8] & ~oh) | ((en && t >= bstart) ? oh : 4'b0);
         #1;
         exp_bv = (t >= bstart) && (t <= bc);
         chk("m_awready", t, ob_m_awready, (t == awc));
         chk("m_wready", t, ob_m_wready, (t == wc));
         chk("s_awvalid", t, ob_s_awvalid, (en && t >= 1 && t <= awc) ? oh : 4'b0);
         chk("s_wvalid", t, ob_s_wvalid, (en && t >= 1 && t <= wc) ? oh : 4'b0);
         chk("m_bvalid", t, ob_m_bvalid, exp_bv);
         chk("m_bresp", t, ob_m_bresp, exp_bv ? (en ? bresp : 2'b11) : 2'b00);
         chk("s_bready", t, ob_s_bready,
             (en && t >= r && t <= bc && t >= bready_at) ? oh : 4'b0);
         if (t >= 1) chk("s_awaddr", t, ob_s_awaddr, addr);
         if (ob_s_wvalid != 4'b0) begin
            chk("s_wdata", t, ob_s_wdata, data);
            chk("s_wstrb", t, ob_s_wstrb, strb);
         end
         if (m_awvalid && ob_m_awready) aw_pend = 1'b0;
         if (m_wvalid && ob_m_wready) w_pend = 1'b0;
         if (ob_m_bvalid && m_bready) done = 1'b1;
         if (t == abort_at) begin
            rst = 1'b1;
            @(negedge clk);
            chk_quiet("abort");
            rst  = 1'b0;
            done = 1'b1;
         end else begin
            @(negedge clk);
         end
         // Post-decode address changes must not reach the slaves.
         if (!aw_pend) m_awaddr = $urandom;
      end
      chk("write completed", -1, done, 1'b1);
      m_awvalid = 1'b0;
      m_wvalid  = 1'b0;
      m_bready  = 1'b0;
      s_awready = 4'b0;
      s_wready  = 4'b0;
      s_bvalid  = 4'b0;
   endtask

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      use_e     = 1'b0;
      rst       = 1'b1;
      m_awvalid = 1'b1;
      m_wvalid  = 1'b0;
      m_bready  = 1'b0;
      m_awaddr  = 32'h8000_0000;
      m_wdata   = '0;
      m_wstrb   = '0;
      s_awready = 4'hF;
      s_wready  = 4'hF;
      s_bvalid  = 4'hF;
      s_bresp   = '0;

      @(negedge clk);
      chk_quiet("reset1");
      @(negedge clk);
      chk_quiet("reset2");
      rst = 1'b0;

      do_write(32'h8000_0010, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 2'b00, -1);
      do_write(32'h4000_0004, 32'h1234_5678, 4'h3, 4, 0, 0, 0, 2'b00, -1);
      do_write(32'h0000_0020, 32'hCAFE_F00D, 4'hC, 0, 0, 0, 5, 2'b10, -1);

      use_e = 1'b1;
      do_write(32'hC000_0000, 32'hBAD0_BAD0, 4'hF, 0, 0, 0, 1, 2'b00, -1);
      use_e = 1'b0;

      do_write(32'hC000_0100, 32'h5555_AAAA, 4'hF, 0, 0, 0, 1000, 2'b01, 3);
      do_write(32'h0000_0040, 32'h0F0F_0F0F, 4'h1, 0, 0, 0, 0, 2'b00, -1);

      for (int n = 0; n < 40; n++) begin
         logic [31:0] a;
         a     = $urandom;
         use_e = 1'($urandom_range(0, 1));
         do_write(a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 2), $urandom_range(0, 6), 2'($urandom), -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
